// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache:
// FSM state encoding, AXI read-channel constants and address-field width helpers.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } state_t;

  localparam logic [1:0] AXI_INCR    = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B = 3'b010;
  localparam logic [1:0] AXI_OKAY    = 2'b00;

  localparam int unsigned ADDR_W = 32;

  function automatic int unsigned off_w(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  function automatic int unsigned idx_w(input int unsigned lines);
    return $clog2(lines);
  endfunction

  // Word offset plus byte offset plus index are removed from the address.
  function automatic int unsigned tag_w(input int unsigned lines,
                                        input int unsigned line_words);
    return ADDR_W - 2 - off_w(line_words) - idx_w(lines);
  endfunction

endpackage

// File: rtl/icache_store.sv
// Valid/tag/data arrays of the instruction cache: flop storage with one
// write port (word or line) and an asynchronous read addressed by index/offset.
module icache_store
  import icache_pkg::*;
#(
  parameter int unsigned LINES      = 64,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                clr_all_i,
  input  logic                                word_we_i,
  input  logic [idx_w(LINES)-1:0]             widx_i,
  input  logic [off_w(LINE_WORDS)-1:0]        woff_i,
  input  logic [31:0]                         wdata_i,
  input  logic                                line_we_i,
  input  logic [tag_w(LINES,LINE_WORDS)-1:0]  wtag_i,
  input  logic                                wvalid_i,
  input  logic [idx_w(LINES)-1:0]             ridx_i,
  input  logic [off_w(LINE_WORDS)-1:0]        roff_i,
  output logic                                rvalid_o,
  output logic [tag_w(LINES,LINE_WORDS)-1:0]  rtag_o,
  output logic [31:0]                         rdata_o
);

  localparam int unsigned TAG = tag_w(LINES, LINE_WORDS);

  logic [LINES-1:0] valid_q;
  logic [TAG-1:0]   tag_q  [LINES];
  logic [31:0]      data_q [LINES][LINE_WORDS];

  // Whole-cache invalidation takes priority over a line completing in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || clr_all_i) begin
      valid_q <= '0;
    end else if (line_we_i) begin
      valid_q[widx_i] <= wvalid_i;
    end
  end

  always_ff @(posedge clk) begin
    if (word_we_i) begin
      data_q[widx_i][woff_i] <= wdata_i;
    end
    if (line_we_i) begin
      tag_q[widx_i] <= wtag_i;
    end
  end

  assign rvalid_o = valid_q[ridx_i];
  assign rtag_o   = tag_q[ridx_i];
  assign rdata_o  = data_q[ridx_i][roff_i];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with AXI4 line refill.
// Optional macro ICACHE_PERF_EN adds hit_cnt/miss_cnt performance counters.
module icache_dm
  import icache_pkg::*;
#(
  parameter int unsigned LINES      = 64,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  output logic        stall,
  input  logic        inv,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int unsigned OFF = off_w(LINE_WORDS);
  localparam int unsigned IDX = idx_w(LINES);
  localparam int unsigned TAG = tag_w(LINES, LINE_WORDS);

  state_t               state_q, state_d;
  logic [TAG+IDX-1:0]   miss_addr_q, miss_addr_d;
  logic [OFF-1:0]       beat_q, beat_d;
  logic                 fill_err_q, fill_err_d;
  logic                 inv_pend_q, inv_pend_d;

  logic [OFF-1:0]       pc_off;
  logic [IDX-1:0]       pc_idx;
  logic [TAG-1:0]       pc_tag;
  logic                 unused_pc;

  logic                 st_valid;
  logic [TAG-1:0]       st_tag;
  logic                 hit;
  logic                 miss;
  logic                 word_we;
  logic                 line_we;
  logic                 line_valid;

  assign pc_off    = pc[OFF+1:2];
  assign pc_idx    = pc[OFF+IDX+1:OFF+2];
  assign pc_tag    = pc[31:OFF+IDX+2];
  assign unused_pc = ^pc[1:0];

  icache_store #(
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS)
  ) u_store (
    .clk       (clk),
    .reset     (reset),
    .clr_all_i (inv),
    .word_we_i (word_we),
    .widx_i    (miss_addr_q[IDX-1:0]),
    .woff_i    (beat_q),
    .wdata_i   (rdata),
    .line_we_i (line_we),
    .wtag_i    (miss_addr_q[TAG+IDX-1:IDX]),
    .wvalid_i  (line_valid),
    .ridx_i    (pc_idx),
    .roff_i    (pc_off),
    .rvalid_o  (st_valid),
    .rtag_o    (st_tag),
    .rdata_o   (instr)
  );

  assign hit     = st_valid && (st_tag == pc_tag);
  assign araddr  = {miss_addr_q, {(OFF+2){1'b0}}};
  assign arlen   = 8'(LINE_WORDS - 1);
  assign arsize  = AXI_SIZE_4B;
  assign arburst = AXI_INCR;
  assign stall   = (state_q != IDLE) || miss;

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    beat_d      = beat_q;
    fill_err_d  = fill_err_q;
    inv_pend_d  = inv_pend_q || inv;
    miss        = 1'b0;
    arvalid     = 1'b0;
    rready      = 1'b0;
    word_we     = 1'b0;
    line_we     = 1'b0;
    line_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        inv_pend_d = 1'b0;
        miss       = !hit;
        if (!hit) begin
          miss_addr_d = {pc_tag, pc_idx};
          fill_err_d  = 1'b0;
          state_d     = REQ;
        end
      end
      REQ: begin
        arvalid = 1'b1;
        if (arready) begin
          beat_d  = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        rready = 1'b1;
        if (rvalid) begin
          word_we    = 1'b1;
          fill_err_d = fill_err_q || (rresp != AXI_OKAY);
          beat_d     = beat_q + OFF'(1);
          if (rlast) begin
            // A line is only trusted if every beat was OKAY and no invalidate hit it.
            line_we    = 1'b1;
            line_valid = !fill_err_q && (rresp == AXI_OKAY) && !inv_pend_q && !inv;
            inv_pend_d = 1'b0;
            state_d    = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      beat_q      <= '0;
      fill_err_q  <= 1'b0;
      inv_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      beat_q      <= beat_d;
      fill_err_q  <= fill_err_d;
      inv_pend_q  <= inv_pend_d;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == IDLE) begin
      if (hit) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Directed self-checking bench for icache_dm: cold fetch, same-line hits, conflict,
// backpressure, error/invalidate refetch, reset abort and (with ICACHE_PERF_EN) counters.
module tb_icache_dm;

  localparam int LW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        stall;
  logic        inv;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  int checks = 0;
  int fails  = 0;

  icache_dm #(
    .LINES      (64),
    .LINE_WORDS (LW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .pc      (pc),
    .instr   (instr),
    .stall   (stall),
    .inv     (inv),
    .araddr  (araddr),
    .arlen   (arlen),
    .arsize  (arsize),
    .arburst (arburst),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rlast   (rlast),
    .rvalid  (rvalid),
    .rready  (rready)
`ifdef ICACHE_PERF_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset   = 1'b1;
    pc      = 32'h40;
    inv     = 1'b0;
    arready = 1'b0;
    rvalid  = 1'b0;
    rlast   = 1'b0;
    rresp   = 2'b00;
    rdata   = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Acts as the AXI slave for one miss; returns at the negedge after the rlast edge.
  task automatic run_miss(input logic [31:0] addr, input logic [31:0] exp_ar,
                          input logic [31:0] d0, input int ar_wait, input int gap,
                          input int err_beat, input int inv_beat, output int stall_cyc);
    int phase = 0;
    int beat  = 0;
    int gapc  = 0;
    int waitc = 0;
    bit inv_done = 1'b0;
    stall_cyc = 0;
    pc = addr;
    for (int cyc = 0; cyc < 200 && phase != 2; cyc++) begin
      arready = (phase == 0) && (waitc >= ar_wait);
      rvalid  = (phase == 1) && (gapc >= gap);
      rdata   = rvalid ? d0 + beat : 32'hDEAD_0000 + cyc;
      rlast   = rvalid && (beat == LW - 1);
      rresp   = (rvalid && beat == err_beat) ? 2'b10 : 2'b00;
      inv     = (phase == 1) && (beat == inv_beat) && !inv_done;
      if (inv) inv_done = 1'b1;
      #1;
      if (stall) stall_cyc++;
      if (arvalid) begin
        checks++;
        if (phase != 0 || araddr !== exp_ar) begin
          fails++;
          $display("FAIL araddr: got %h (phase %0d) expected %h", araddr, phase, exp_ar);
        end
      end
      checks++;
      if (rready !== (phase == 1)) begin
        fails++;
        $display("FAIL rready: got %b expected %b (phase %0d)", rready, (phase == 1), phase);
      end
      if (phase == 0 && arvalid && arready) phase = 1;
      else if (phase == 0 && arvalid) waitc++;
      else if (phase == 1) begin
        if (rvalid) begin
          beat++;
          gapc = 0;
          if (rlast) phase = 2;
        end else begin
          gapc++;
        end
      end
      @(negedge clk);
    end
    arready = 1'b0;
    rvalid  = 1'b0;
    rlast   = 1'b0;
    rresp   = 2'b00;
    rdata   = 32'h0;
    inv     = 1'b0;
    checks++;
    if (phase != 2) begin
      fails++;
      $display("FAIL refill_timeout: phase %0d expected 2 for pc %h", phase, addr);
    end
  endtask

  task automatic check_hit(input logic [31:0] addr, input logic [31:0] exp);
    pc = addr;
    #1;
    checks++;
    if (stall !== 1'b0 || instr !== exp || arvalid !== 1'b0) begin
      fails++;
      $display("FAIL hit %h: got instr %h stall %b arvalid %b expected instr %h stall 0 arvalid 0",
               addr, instr, stall, arvalid, exp);
    end
    @(negedge clk);
  endtask

  task automatic check_stall_cnt(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s stall cycles: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_miss_now(input string name, input logic [31:0] addr);
    pc = addr;
    #1;
    checks++;
    if (stall !== 1'b1 || arvalid !== 1'b0) begin
      fails++;
      $display("FAIL %s: got stall %b arvalid %b expected stall 1 arvalid 0", name, stall, arvalid);
    end
  endtask

  task automatic test_reset();
    do_reset();
    pc = 32'h40;
    #1;
    checks++;
    if (stall !== 1'b1 || arvalid !== 1'b0 || rready !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got stall %b arvalid %b rready %b expected 1 0 0", stall, arvalid, rready);
    end
    checks++;
    if (arlen !== 8'd3 || arsize !== 3'b010 || arburst !== 2'b01) begin
      fails++;
      $display("FAIL ar_consts: got len %h size %b burst %b expected 03 010 01", arlen, arsize, arburst);
    end
  endtask

  task automatic test_cold_fetch();
    int n;
    run_miss(32'h40, 32'h40, 32'hA0, 0, 0, -1, -1, n);
    check_stall_cnt("cold", n, 6);
    check_hit(32'h40, 32'hA0);
  endtask

  task automatic test_same_line();
    check_hit(32'h44, 32'hA1);
    check_hit(32'h48, 32'hA2);
    check_hit(32'h4C, 32'hA3);
  endtask

  task automatic test_conflict();
    int n;
    run_miss(32'h1040, 32'h1040, 32'hB0, 0, 0, -1, -1, n);
    check_stall_cnt("conflict", n, 6);
    check_hit(32'h1040, 32'hB0);
    check_hit(32'h104C, 32'hB3);
    check_miss_now("conflict_evict", 32'h40);
    run_miss(32'h40, 32'h40, 32'hA0, 0, 0, -1, -1, n);
    check_hit(32'h48, 32'hA2);
  endtask

  task automatic test_backpressure();
    int n;
    run_miss(32'h80, 32'h80, 32'hC0, 3, 2, -1, -1, n);
    check_stall_cnt("backpressure", n, 17);
    check_hit(32'h80, 32'hC0);
    check_hit(32'h84, 32'hC1);
    check_hit(32'h88, 32'hC2);
    check_hit(32'h8C, 32'hC3);
  endtask

  task automatic test_error();
    int n;
    run_miss(32'hC0, 32'hC0, 32'hE0, 0, 0, 2, -1, n);
    check_stall_cnt("error", n, 6);
    check_miss_now("error_refetch", 32'hC0);
    run_miss(32'hC0, 32'hC0, 32'hE0, 0, 0, -1, -1, n);
    check_stall_cnt("error_retry", n, 6);
    check_hit(32'hC8, 32'hE2);
  endtask

  task automatic test_inv();
    int n;
    run_miss(32'h100, 32'h100, 32'hF0, 0, 0, -1, 1, n);
    check_stall_cnt("inv_fill", n, 6);
    check_miss_now("inv_refetch", 32'h100);
    run_miss(32'h100, 32'h100, 32'hF0, 0, 0, -1, -1, n);
    check_hit(32'h104, 32'hF1);
    check_miss_now("inv_all_lines", 32'h44);
    run_miss(32'h44, 32'h40, 32'hA0, 0, 0, -1, -1, n);
    check_hit(32'h44, 32'hA1);
  endtask

  task automatic test_reset_abort();
    pc = 32'h200;
    #1;
    @(negedge clk);
    #1;
    checks++;
    if (arvalid !== 1'b1 || araddr !== 32'h200) begin
      fails++;
      $display("FAIL abort_req: got arvalid %b araddr %h expected 1 00000200", arvalid, araddr);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (arvalid !== 1'b0 || rready !== 1'b0 || stall !== 1'b1) begin
      fails++;
      $display("FAIL abort_idle: got arvalid %b rready %b stall %b expected 0 0 1", arvalid, rready, stall);
    end
    check_miss_now("abort_cleared", 32'h104);
  endtask

`ifdef ICACHE_PERF_EN
  task automatic test_perf();
    int n;
    do_reset();
    run_miss(32'h40, 32'h40, 32'hA0, 0, 0, -1, -1, n);
    check_hit(32'h40, 32'hA0);
    check_hit(32'h44, 32'hA1);
    check_hit(32'h48, 32'hA2);
    check_hit(32'h4C, 32'hA3);
    #1;
    checks++;
    if (hit_cnt !== 32'd4 || miss_cnt !== 32'd1) begin
      fails++;
      $display("FAIL perf: got hit %0d miss %0d expected hit 4 miss 1", hit_cnt, miss_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_cold_fetch();
    test_same_line();
    test_conflict();
    test_backpressure();
    test_error();
    test_inv();
    test_reset_abort();
`ifdef ICACHE_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/icache_dm.md
# icache_dm

Direct-mapped, read-only instruction cache that sits directly upstream of the single-cycle MIPS core. It serves `instr` for the core's `pc` combinationally on a hit. On a miss it stalls the core and refills one line through an AXI4 read-address/read-data channel pair. The core holds `pc` stable whenever `stall` is high.

## Interface
Parameters:
- `LINES`, 64: number of lines; power of two, at least 2.
- `LINE_WORDS`, 4: 32-bit words per line; power of two, 2 to 16.

Ports:
- `clk` input, 1: the single clock.
- `reset` input, 1: synchronous, active-high.
- `pc` input, 32: fetch address from the core; bits [1:0] ignored.
- `instr` output, 32: instruction word for `pc`; valid when `stall`=0.
- `stall` output, 1: miss in progress; core must hold `pc` and suppress state update.
- `inv` input, 1: one-cycle pulse that invalidates the whole cache.
- `araddr` output, 32: line-aligned refill address.
- `arlen` output, 8: constant `LINE_WORDS`-1.
- `arsize` output, 3: constant 3'b010.
- `arburst` output, 2: constant 2'b01 (INCR).
- `arvalid` output, 1; `arready` input, 1.
- `rdata` input, 32; `rresp` input, 2; `rlast` input, 1; `rvalid` input, 1; `rready` output, 1.
- `hit_cnt`, `miss_cnt` outputs, 32 each: present only with `ICACHE_PERF_EN`.

## Operation
- Address split: offset = `pc`[OFF+1:2] with OFF=log2(`LINE_WORDS`); index = next log2(`LINES`) bits; tag = remaining upper bits.
- Storage: per line, 1 valid bit, 1 tag and `LINE_WORDS` data words. Storage is flops, read asynchronously.
- Hit = valid[index] & (tag match). On a hit, `instr` = data[index][offset] and `stall`=0.
- FSM states:
  - IDLE: on a miss, latch `{tag,index}` into `miss_addr`, clear `fill_err`, go to REQ. `stall` is high in the same cycle as the miss.
  - REQ: `arvalid`=1 and `araddr`={`miss_addr`, OFF+2 zero bits}. Both are held stable until `arready`. On handshake go to FILL with `beat`=0.
  - FILL: `rready`=1. On each `rvalid`, write `rdata` to data[index][`beat`], OR (`rresp`!=0) into `fill_err`, then `beat`++. On `rvalid&rlast`, write tag, set valid only if `fill_err`=0, no error on this beat and no `inv` was seen during the fill, then go to IDLE.
- `stall` = (state!=IDLE) | miss. In IDLE, `arvalid` and `rready` are 0.
- A beat with `rlast` arriving before `LINE_WORDS` beats still ends the fill and validates the line. Beats beyond `beat`=`LINE_WORDS`-1 are never accepted, because `rlast` is required on that beat.
- Error line: the line stays invalid, so the next IDLE cycle misses again and refetches. There is no retry limit.
- `inv`: clears all valid bits next edge, in any state. If asserted in REQ or FILL, it also sets `inv_pend`. The fill still completes on the bus but does not set valid. `inv_pend` clears on return to IDLE.
- `inv` and a refill completing in the same cycle: invalidation wins and the line is left invalid.

## Timing
- Hit: 0-cycle latency, combinational `pc`→`instr`.
- Miss cycle count: 1 (detect) + REQ cycles until `arready` + FILL beats; the next IDLE cycle hits. With `arready` and `rvalid` held high and `LINE_WORDS`=4, the core stalls for 6 cycles.
- Reset values:
  - State IDLE; all valid bits 0; `arvalid`=0; `rready`=0; `beat`=0; `inv_pend`=0; `fill_err`=0; counters 0.
  - `stall`=1 after reset whenever `pc` misses, which is always on the first fetch.
- Reset mid-REQ or mid-FILL aborts immediately. The AXI slave shares `reset`, so no stale beats arrive afterwards.

## Configuration
- `ICACHE_PERF_EN` defined: `hit_cnt` increments on every IDLE cycle with a hit. `miss_cnt` increments on every IDLE→REQ transition. Both wrap at 2^32 and both are cleared by `reset` but not by `inv`.
- `ICACHE_PERF_EN` not defined: the counter ports and logic are absent.

## Structure
- `icache_pkg` holds:
  - state encoding IDLE/REQ/FILL;
  - AXI constants: INCR=2'b01, SIZE_4B=3'b010, OKAY=2'b00;
  - localparam helpers for OFF, IDX and TAG widths.
- Sub-module `icache_store`: the valid/tag/data arrays with one write port and an asynchronous read on index. The FSM and counters stay in `icache_dm`.

## Test plan
- Cold fetch: reset, then `pc`=0x0000_0040, slave with `arready` and `rvalid` held high returning 0xA0..0xA3. Required: `araddr`=0x40 and `arlen`=3; `stall` high for 6 cycles; then `instr`=0xA0 with `stall`=0.
- Same line: after the cold fetch, `pc`=0x44, 0x48, 0x4C. Required: `instr`=0xA1, 0xA2, 0xA3 with no AR request.
- Conflict: with `LINES`=64 and line 0x40 valid, fetch `pc`=0x1040. Required: refill at `araddr`=0x1040. A following fetch of 0x40 misses again.
- Backpressure: `arready` low for 3 cycles, `rvalid` gaps between beats. Required: `araddr` stable throughout REQ; data is written only on `rvalid`.
- Error and invalidate:
  - `rresp`=2'b10 on beat 2: the line stays invalid and is refetched.
  - `inv` pulsed during FILL: the fill completes on the bus, but the next fetch misses.
- Perf (`ICACHE_PERF_EN` defined): run the cold-fetch and same-line sequences in order. Required: `miss_cnt`=1 and `hit_cnt`=4.
